// File: rtl/sae_arbiter.sv
// sae_arbiter: round-robin share of one sae core between two requesters.
// One transaction in flight; the core is watched by a timeout counter so a
// silent core still produces a (timeout-flagged) response.
module sae_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  // requester 0
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [1:0] req0_mode,
  input  logic [7:0] req0_data,
  input  logic [7:0] req0_key,
  output logic       resp0_valid,
  input  logic       resp0_ready,
  // requester 1
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [1:0] req1_mode,
  input  logic [7:0] req1_data,
  input  logic [7:0] req1_key,
  output logic       resp1_valid,
  input  logic       resp1_ready,
  // shared response payload
  output logic [7:0] resp_data,
  output logic [3:0] resp_err,
  // sae core side
  output logic [1:0] core_mode,
  output logic [7:0] core_data_input,
  output logic [7:0] core_key_input,
  output logic       core_inputs_valid,
  input  logic [7:0] core_data_output,
  input  logic       core_output_ready,
  input  logic       core_err_ptxt,
  input  logic       core_err_seckey,
  input  logic       core_err_ctxt,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] data;
    logic [7:0] key;
  } req_t;

  state_e        state_q, state_d;
  req_t          cap_q, cap_d;
  logic          gnt_q, gnt_d;     // channel currently being served
  logic          last_q, last_d;   // channel served most recently
  logic [TW-1:0] tmr_q, tmr_d;
  logic [TW-1:0] tmr_inc;
  logic [7:0]    rdata_q, rdata_d;
  logic [3:0]    rerr_q, rerr_d;
  logic          sel;

  // On a tie the channel that did not win last time is chosen.
  always_comb begin
    sel = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  end

  // Saturating timer step; it can never wrap past TIMEOUT_CYCLES.
  always_comb begin
    tmr_inc = (tmr_q == TW'(TIMEOUT_CYCLES)) ? tmr_q : tmr_q + TW'(1);
  end

  // Next-state and output decode.
  always_comb begin
    state_d           = state_q;
    cap_d             = cap_q;
    gnt_d             = gnt_q;
    last_d            = last_q;
    tmr_d             = tmr_q;
    rdata_d           = rdata_q;
    rerr_d            = rerr_q;
    req0_ready        = 1'b0;
    req1_ready        = 1'b0;
    resp0_valid       = 1'b0;
    resp1_valid       = 1'b0;
    core_mode         = '0;
    core_data_input   = '0;
    core_key_input    = '0;
    core_inputs_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // ready is gated by reset so every output is quiet while held in reset
        if ((req0_valid || req1_valid) && rst_n) begin
          req0_ready = ~sel;
          req1_ready = sel;
          gnt_d      = sel;
          cap_d      = sel ? req_t'{req1_mode, req1_data, req1_key}
                           : req_t'{req0_mode, req0_data, req0_key};
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        core_inputs_valid = 1'b1;
        core_mode         = cap_q.mode;
        core_data_input   = cap_q.data;
        core_key_input    = cap_q.key;
        tmr_d             = '0;
        state_d           = S_WAIT;
      end
      S_WAIT: begin
        core_mode       = cap_q.mode;
        core_data_input = cap_q.data;
        core_key_input  = cap_q.key;
        tmr_d           = tmr_inc;
        // a core answer on the final cycle still beats the timeout
        if (core_output_ready) begin
          rdata_d = core_data_output;
          rerr_d  = {1'b0, core_err_ctxt, core_err_seckey, core_err_ptxt};
          state_d = S_RESP;
        end else if (tmr_inc == TW'(TIMEOUT_CYCLES)) begin
          rdata_d = '0;
          rerr_d  = 4'b1000;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        resp0_valid = ~gnt_q;
        resp1_valid = gnt_q;
        if (gnt_q ? resp1_ready : resp0_ready) begin
          last_d  = gnt_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and capture registers; last grant resets to ch1 so ch0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cap_q   <= '0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      tmr_q   <= '0;
      rdata_q <= '0;
      rerr_q  <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      tmr_q   <= tmr_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  assign resp_data = rdata_q;
  assign resp_err  = rerr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sae_arbiter.sv
// Bench for sae_arbiter: directed scenarios plus a randomized phase.
// A core model answers each issue and pushes the expected response; a
// monitor checks grants, core outputs and responses against that queue.
module tb_sae_arbiter;
  localparam int TMO = 8;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_mode = '0, req1_mode = '0;
  logic [7:0] req0_data = '0, req1_data = '0, req0_key = '0, req1_key = '0;
  logic       resp0_valid, resp1_valid;
  logic       resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [7:0] resp_data;
  logic [3:0] resp_err;
  logic [1:0] core_mode;
  logic [7:0] core_data_input, core_key_input;
  logic       core_inputs_valid, busy;
  logic [7:0] core_data_output = '0;
  logic       core_output_ready = 1'b0;
  logic       core_err_ptxt = 1'b0, core_err_seckey = 1'b0, core_err_ctxt = 1'b0;

  sae_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
    .req0_data(req0_data), .req0_key(req0_key),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
    .req1_data(req1_data), .req1_key(req1_key),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .core_mode(core_mode), .core_data_input(core_data_input),
    .core_key_input(core_key_input), .core_inputs_valid(core_inputs_valid),
    .core_data_output(core_data_output), .core_output_ready(core_output_ready),
    .core_err_ptxt(core_err_ptxt), .core_err_seckey(core_err_seckey),
    .core_err_ctxt(core_err_ctxt), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_fail = 0;

  typedef struct {
    bit         ch;
    logic [7:0] data;
    logic [3:0] err;
    int         cyc;   // cycle in which the response must first appear
  } exp_t;
  exp_t sb[$];

  // reference arbitration state
  bit         inflight = 1'b0, last_m = 1'b1, seen = 1'b0;
  bit         acc_ch = 1'b0;
  logic [1:0] acc_mode = '0;
  logic [7:0] acc_data = '0, acc_key = '0;

  // core behaviour: lat 0 = never answers, 1..N = answer in WAIT cycle lat-1
  bit         cfg_rand = 1'b0;
  int         cfg_lat = 1;
  logic [7:0] cfg_data = '0;
  logic [2:0] cfg_err = '0;
  bit         rand_rr = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    inflight = 1'b0;
    last_m   = 1'b1;
    seen     = 1'b0;
  endtask

  task automatic chk_all_zero(string nm);
    chk(nm, {req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data, resp_err,
             core_mode, core_data_input, core_key_input, core_inputs_valid, busy}, 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 chk_all_zero("reset_outputs");
    model_reset();
    @(negedge clk) rst_n = 1'b1;
  endtask

  // Present one request and hold it until accepted.
  task automatic send(bit ch, logic [1:0] m, logic [7:0] d, logic [7:0] k);
    bit hs = 1'b0;
    @(posedge clk); #1;
    if (ch) begin req1_mode = m; req1_data = d; req1_key = k; req1_valid = 1'b1; end
    else    begin req0_mode = m; req0_data = d; req0_key = k; req0_valid = 1'b1; end
    for (int i = 0; i < 400 && !hs; i++) begin
      @(negedge clk);
      hs = ch ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
    end
    chk("accept_timeout", hs, 1);
    @(posedge clk); #1;
    if (ch) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    while ((sb.size() != 0 || inflight) && i < 300) begin
      @(posedge clk);
      i++;
    end
    chk("drain_timeout", (sb.size() != 0 || inflight), 0);
    @(posedge clk); #1;
  endtask

  // Core model: on each issue, decide the answer and push the expected response.
  initial begin
    int lat;
    logic [7:0] dat;
    logic [2:0] e3;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && core_inputs_valid) begin
        chk("core_mode", core_mode, acc_mode);
        chk("core_data", core_data_input, acc_data);
        chk("core_key", core_key_input, acc_key);
        if (cfg_rand) begin
          lat = $urandom_range(0, TMO + 1);
          dat = 8'($urandom);
          e3  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
        end else begin
          lat = cfg_lat; dat = cfg_data; e3 = cfg_err;
        end
        e.ch = acc_ch;
        if (lat >= 1 && lat <= TMO) begin
          e.data = dat; e.err = {1'b0, e3}; e.cyc = cyc + 1 + lat;
        end else begin
          e.data = 8'h00; e.err = 4'b1000; e.cyc = cyc + 1 + TMO;
        end
        sb.push_back(e);
        if (lat != 0) begin
          for (int i = 1; i <= lat; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
              chk("wait_iv", core_inputs_valid, 0);
              chk("wait_hold", {core_mode, core_data_input, core_key_input},
                  {acc_mode, acc_data, acc_key});
            end
          end
          core_output_ready = 1'b1;
          core_data_output  = dat;
          {core_err_ctxt, core_err_seckey, core_err_ptxt} = e3;
          @(posedge clk); #1;
          core_output_ready = 1'b0;
          core_data_output  = 8'($urandom);
          {core_err_ctxt, core_err_seckey, core_err_ptxt} = 3'($urandom);
        end
      end
    end
  end

  // Monitor: grant choice, idle core outputs, and scoreboard responses.
  initial begin
    exp_t e;
    bit   g;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("busy", busy, inflight);
        if (inflight) begin
          chk("ready_while_busy", {req1_ready, req0_ready}, 0);
        end else begin
          chk("core_idle", {core_inputs_valid, core_mode, core_data_input, core_key_input}, 0);
          if (req0_valid || req1_valid) begin
            g = (req0_valid && req1_valid) ? !last_m : req1_valid;
            chk("grant", {req1_ready, req0_ready}, g ? 2'b10 : 2'b01);
            acc_ch   = g;
            acc_mode = g ? req1_mode : req0_mode;
            acc_data = g ? req1_data : req0_data;
            acc_key  = g ? req1_key  : req0_key;
            inflight = 1'b1;
          end else begin
            chk("ready_no_req", {req1_ready, req0_ready}, 0);
          end
        end
        if (resp0_valid || resp1_valid) begin
          if (sb.size() == 0) begin
            chk("resp_unexpected", {resp1_valid, resp0_valid}, 0);
          end else begin
            e = sb[0];
            chk("resp_channel", {resp1_valid, resp0_valid}, e.ch ? 2'b10 : 2'b01);
            chk("resp_data", resp_data, e.data);
            chk("resp_err", resp_err, e.err);
            if (!seen) begin
              chk("resp_latency", cyc, e.cyc);
              seen = 1'b1;
            end
            if (e.ch ? resp1_ready : resp0_ready) begin
              void'(sb.pop_front());
              last_m   = e.ch;
              inflight = 1'b0;
              seen     = 1'b0;
            end
          end
        end
      end
    end
  end

  // Random response back-pressure.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rr) begin
        resp0_ready = 1'($urandom);
        resp1_ready = 1'($urandom);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // Directed scenarios, then randomized traffic.
  initial begin
    bit got;
    #1 chk_all_zero("reset_outputs");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;

    // single ch0 transaction, core answers two cycles after issue
    cfg_lat = 2; cfg_data = 8'h44; cfg_err = 3'b000;
    send(0, 2'b01, 8'h41, 8'h03);
    drain();

    // simultaneous requests from reset: ch0, ch1, ch0, ch1
    do_reset();
    cfg_lat = 1; cfg_data = 8'hA5; cfg_err = 3'b000;
    fork
      send(0, 2'b10, 8'h11, 8'h22);
      send(1, 2'b11, 8'h33, 8'h44);
    join
    fork
      send(0, 2'b00, 8'h55, 8'h66);
      send(1, 2'b01, 8'h77, 8'h88);
    join
    drain();

    // invalid secret key reported by the core
    cfg_lat = 3; cfg_data = 8'h00; cfg_err = 3'b010;
    send(1, 2'b01, 8'h5A, 8'hFF);
    drain();

    // silent core -> timeout, then the next request is served
    cfg_lat = 0;
    send(0, 2'b10, 8'h12, 8'h34);
    drain();
    cfg_lat = 1; cfg_data = 8'h9C; cfg_err = 3'b000;
    send(1, 2'b00, 8'h21, 8'h43);
    drain();
    // answer on the last WAIT cycle beats the timeout
    cfg_lat = TMO; cfg_data = 8'h7E; cfg_err = 3'b101;
    send(0, 2'b11, 8'h01, 8'h02);
    drain();
    // answer one cycle too late is ignored
    cfg_lat = TMO + 1; cfg_data = 8'hEE; cfg_err = 3'b111;
    send(1, 2'b01, 8'h03, 8'h04);
    drain();

    // resp0 held off for 5 cycles while ch1 waits
    cfg_lat = 1; cfg_data = 8'hC3; cfg_err = 3'b001;
    resp0_ready = 1'b0;
    send(0, 2'b01, 8'h61, 8'h07);
    fork
      send(1, 2'b10, 8'h62, 8'h08);
      begin
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
          @(negedge clk);
          got = resp0_valid;
        end
        chk("stall_resp_seen", got, 1);
        repeat (5) @(posedge clk);
        #1 resp0_ready = 1'b1;
      end
    join
    drain();

    // reset while waiting on the core aborts the transaction silently
    cfg_lat = 0;
    send(0, 2'b01, 8'h99, 8'h98);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("reset_mid_wait");
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    // randomized traffic on both channels
    cfg_rand = 1'b1;
    rand_rr  = 1'b1;
    fork
      for (int n = 0; n < 30; n++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        send(0, 2'($urandom), 8'($urandom), 8'($urandom));
      end
      for (int n = 0; n < 30; n++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        send(1, 2'($urandom), 8'($urandom), 8'($urandom));
      end
    join
    rand_rr = 1'b0;
    @(posedge clk); #1;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sae_arbiter.md
Name: sae_arbiter

Overview:
- Shares one sae encryption/decryption core between two requesters, ch0 and ch1 (e.g. the walt and jesse endpoints).
- Round-robin arbitration; one transaction in flight at a time.
- Drives the core's mode/data_input/key_input/inputs_valid, then collects data_output, output_ready and the three error flags.
- Returns the result to the granted requester through a valid/ready response handshake. A timeout guards against a core that never answers.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles in WAIT for core output_ready before a timeout response is returned.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req0_valid / req1_valid  input  1  requester has a transaction pending
- req0_ready / req1_ready  output  1  transaction accepted this cycle
- req0_mode / req1_mode  input  2  sae mode, forwarded opaque
- req0_data / req1_data  input  8  plaintext/ciphertext char
- req0_key / req1_key  input  8  secret key
- resp0_valid / resp1_valid  output  1  response available
- resp0_ready / resp1_ready  input  1  requester consumes response
- resp_data  output  8  result char, shared by both channels
- resp_err  output  4  {timeout, invalid_ctxt_char, invalid_seckey, invalid_ptxt_char}
- core_mode  output  2  to sae mode
- core_data_input  output  8  to sae data_input
- core_key_input  output  8  to sae key_input
- core_inputs_valid  output  1  to sae inputs_valid
- core_data_output  input  8  from sae data_output
- core_output_ready  input  1  from sae output_ready
- core_err_ptxt / core_err_seckey / core_err_ctxt  input  1  from sae error flags
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - Every output goes to 0.
  - Capture registers clear.
  - last_grant resets to 1, so ch0 wins the first tie.
  - Asserting reset mid-transaction aborts it; no response is produced.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - reqN_ready is combinational: 1 only for the selected channel.
  - Selection:
    - Only one reqN_valid high: that channel is selected.
    - Both high: the channel != last_grant is selected.
  - On valid&ready, register that channel's mode/data/key and grant id, then go to ISSUE.
  - No req valid: stay in IDLE, all core_* outputs 0.
- ISSUE (exactly 1 cycle):
  - core_inputs_valid=1.
  - core_mode/data/key driven from the capture registers.
  - Timer cleared; go to WAIT.
- WAIT:
  - core_inputs_valid=0; core_mode/data/key held stable from the capture registers.
  - Timer increments every cycle. Width is $clog2(TIMEOUT_CYCLES+1); it never wraps.
  - core_output_ready=1: capture core_data_output into resp_data and {0, ctxt, seckey, ptxt} into resp_err, then go to RESP.
  - Timer reaches TIMEOUT_CYCLES with output_ready=0: resp_data=0, resp_err=4'b1000, go to RESP.
  - output_ready and timeout in the same cycle: output_ready wins.
- RESP:
  - respN_valid=1 for the granted channel only.
  - resp_data/resp_err held until respN_ready=1.
  - On the handshake cycle: last_grant<=granted id, resp regs held, go to IDLE.
  - A new grant may occur in the very next cycle.
- Outside WAIT, core_output_ready and core error inputs are ignored.
- reqN_ready is never asserted outside IDLE. A requester's pending valid is simply held off.
- Minimum latency:
  - Accept at T, core_inputs_valid at T+1.
  - If output_ready at T+2, respN_valid at T+3.

Test Plan:
- Reset mid-WAIT (rst_n=0 while waiting) -> all outputs 0 immediately, state IDLE, no resp0/1_valid after release.
- ch0 only: mode=2'b01, data=8'h41, key=8'h03; core answers 8'h44 two cycles after inputs_valid.
  -> req0_ready 1 cycle; core_inputs_valid 1 cycle carrying 01/41/03; resp0_valid with resp_data=8'h44, resp_err=0; resp1_valid stays 0.
- ch0 and ch1 valid together from reset, then again.
  -> grant order ch0, ch1, ch0, ch1; each response appears only on the granted channel.
- Core returns err_invalid_seckey=1 with data 8'h00 -> resp_err=4'b0010 on the granted channel.
- Core never raises output_ready, TIMEOUT_CYCLES=8.
  -> resp_valid exactly 8 cycles after entering WAIT; resp_err=4'b1000, resp_data=0; arbiter then serves the next request.
- resp0_ready held low 5 cycles while req1_valid=1.
  -> resp_data stable all 5 cycles; req1_ready stays 0 until the cycle after the resp0 handshake.
